// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: byte geometry and the
// loader state encoding used by the FSM in imem_loader.
package imem_loader_pkg;

    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } loaderState_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles an MSB-first byte stream into instruction words and keeps a running
// XOR of every data byte; wordReady flags the cycle the last byte of a word is taken.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
#(
    parameter int DWL = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [BYTE_W-1:0] rxByte,
    output logic [DWL-1:0]    word,
    output logic [BYTE_W-1:0] chk,
    output logic              wordReady
);

    logic [1:0] byteCnt;

    // The shift register is not cleared on a new load: four fresh bytes always
    // overwrite it before the next write strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word    <= '0;
            chk     <= '0;
            byteCnt <= '0;
        end else if (clear) begin
            chk     <= '0;
            byteCnt <= '0;
        end else if (accept) begin
            word    <= {word[DWL-BYTE_W-1:0], rxByte};
            chk     <= chk ^ rxByte;
            byteCnt <= byteCnt + 2'd1;
        end
    end

    assign wordReady = accept && (byteCnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-serial program image into the instruction-memory write port and
// holds the core until every word is written and the trailing XOR checksum matches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int AWL = 6,
    parameter int DWL = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic [AWL:0]      Count,
    input  logic [BYTE_W-1:0] RxData,
    input  logic              RxValid,
    output logic              RxReady,
    output logic              IMWE,
    output logic [AWL-1:0]    IMWA,
    output logic [DWL-1:0]    IMWD,
    output logic              CpuHold,
    output logic              Done,
    output logic              Err
);

    localparam int           DEPTH    = 2 ** AWL;
    localparam logic [AWL:0] MaxCount = (AWL + 1)'(DEPTH);
    localparam logic [AWL:0] OneWord  = (AWL + 1)'(1);

    loaderState_t      state;
    loaderState_t      nextState;
    logic [AWL:0]      countReg;
    logic [AWL:0]      wordCnt;
    logic [BYTE_W-1:0] chk;
    logic              rxAccept;
    logic              packAccept;
    logic              wordReady;
    logic              countOk;
    logic              startAllowed;
    logic              loadStart;

    assign RxReady      = (state == RECV) || (state == CHECK);
    assign rxAccept     = RxValid && RxReady;
    assign packAccept   = rxAccept && (state == RECV);
    assign countOk      = (Count != '0) && (Count <= MaxCount);
    assign startAllowed = (state == IDLE) || (state == DONE) || (state == ERR);
    assign loadStart    = Start && startAllowed && countOk;

    imem_loader_byte_packer #(
        .DWL(DWL)
    ) packer (
        .clk      (CLK),
        .rst      (RST),
        .clear    (loadStart),
        .accept   (packAccept),
        .rxByte   (RxData),
        .word     (IMWD),
        .chk      (chk),
        .wordReady(wordReady)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Start is only honoured while idle or parked in DONE/ERR; mid-load pulses are ignored.
    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (Start) begin
                    nextState = countOk ? RECV : ERR;
                end
            end
            RECV: begin
                if (wordReady) begin
                    nextState = WRITE;
                end
            end
            WRITE: begin
                nextState = ((wordCnt + OneWord) == countReg) ? CHECK : RECV;
            end
            CHECK: begin
                if (rxAccept) begin
                    nextState = (RxData == chk) ? DONE : ERR;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            countReg <= '0;
            wordCnt  <= '0;
        end else if (loadStart) begin
            countReg <= Count;
            wordCnt  <= '0;
        end else if (state == WRITE) begin
            wordCnt <= wordCnt + OneWord;
        end
    end

    // Port strobes are pure decodes of the state register so reset drops them at once.
    assign IMWE    = (state == WRITE);
    assign IMWA    = wordCnt[AWL-1:0];
    assign CpuHold = (state != DONE);
    assign Done    = (state == DONE);
    assign Err     = (state == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: a word-level model predicts the
// write sequence, the checksum byte and the final Done/Err/CpuHold status.
module tb_imem_loader;

    localparam int AWL   = 6;
    localparam int DWL   = 32;
    localparam int DEPTH = 2 ** AWL;

    logic           CLK = 1'b0;
    logic           RST;
    logic           Start;
    logic [AWL:0]   Count;
    logic [7:0]     RxData;
    logic           RxValid;
    logic           RxReady;
    logic           IMWE;
    logic [AWL-1:0] IMWA;
    logic [DWL-1:0] IMWD;
    logic           CpuHold;
    logic           Done;
    logic           Err;

    int errors = 0;
    int checks = 0;
    int rxReadyCycles = 0;

    logic [31:0]        refWords[$];
    logic [7:0]         stream[$];
    logic [AWL+DWL-1:0] writes[$];

    imem_loader #(
        .AWL(AWL),
        .DWL(DWL)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .Start  (Start),
        .Count  (Count),
        .RxData (RxData),
        .RxValid(RxValid),
        .RxReady(RxReady),
        .IMWE   (IMWE),
        .IMWA   (IMWA),
        .IMWD   (IMWD),
        .CpuHold(CpuHold),
        .Done   (Done),
        .Err    (Err)
    );

    always #5 CLK = ~CLK;

    // Every cycle with IMWE high is logged, so a stretched strobe shows up as an extra write.
    always @(negedge CLK) begin
        if (IMWE === 1'b1) writes.push_back({IMWA, IMWD});
        if (RxReady === 1'b1) rxReadyCycles++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] modelChecksum();
        logic [7:0] c = 8'h00;
        foreach (refWords[i]) c = c ^ refWords[i][31:24] ^ refWords[i][23:16]
                                    ^ refWords[i][15:8] ^ refWords[i][7:0];
        return c;
    endfunction

    task automatic buildStream(input logic [7:0] chkDelta);
        stream.delete();
        foreach (refWords[i]) begin
            for (int b = 3; b >= 0; b--) stream.push_back(refWords[i][8*b +: 8]);
        end
        stream.push_back(modelChecksum() ^ chkDelta);
    endtask

    task automatic fillRandom(input int n);
        refWords.delete();
        repeat (n) refWords.push_back($urandom);
    endtask

    task automatic pulseStart(input int count);
        Start = 1'b1;
        Count = count[AWL:0];
        @(negedge CLK);
        Start = 1'b0;
    endtask

    // Offers stream bytes from negedge to negedge; a byte advances only when taken.
    task automatic sendStream(input int upTo, input bit gaps, input int midStartIdx);
        int  idx = 0;
        int  budget = 0;
        bit  midDone = 1'b0;
        bit  acc;
        while (idx < upTo && budget < 4000) begin
            RxData  = stream[idx];
            RxValid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx == midStartIdx && !midDone) begin
                Start   = 1'b1;
                Count   = 1;
                midDone = 1'b1;
            end else begin
                Start = 1'b0;
            end
            #1;
            acc = RxValid && RxReady;
            @(negedge CLK);
            if (acc) idx++;
            budget++;
        end
        Start   = 1'b0;
        RxValid = 1'b0;
        checkOutput("bytes accepted", 64'(idx), 64'(upTo));
    endtask

    task automatic applyStimulus(input int count, input logic [7:0] chkDelta,
                                 input bit gaps, input int midStartIdx);
        writes.delete();
        buildStream(chkDelta);
        pulseStart(count);
        sendStream(stream.size(), gaps, midStartIdx);
        repeat (3) @(negedge CLK);
    endtask

    task automatic verifyLoad(input string tag, input bit expectGood);
        int n;
        checkOutput({tag, " write count"}, 64'(writes.size()), 64'(refWords.size()));
        n = (writes.size() < refWords.size()) ? writes.size() : refWords.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s write %0d", tag, i), 64'(writes[i]),
                        64'({i[AWL-1:0], refWords[i]}));
        end
        checkOutput({tag, " Done"},    64'(Done),    64'(expectGood));
        checkOutput({tag, " Err"},     64'(Err),     64'(!expectGood));
        checkOutput({tag, " CpuHold"}, 64'(CpuHold), 64'(!expectGood));
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " IMWE"},    64'(IMWE),    64'(0));
        checkOutput({tag, " IMWA"},    64'(IMWA),    64'(0));
        checkOutput({tag, " IMWD"},    64'(IMWD),    64'(0));
        checkOutput({tag, " CpuHold"}, 64'(CpuHold), 64'(1));
        checkOutput({tag, " Done"},    64'(Done),    64'(0));
        checkOutput({tag, " Err"},     64'(Err),     64'(0));
        checkOutput({tag, " RxReady"}, 64'(RxReady), 64'(0));
    endtask

    initial begin
        RST     = 1'b1;
        Start   = 1'b0;
        Count   = '0;
        RxData  = '0;
        RxValid = 1'b0;
        #1;
        checkResetValues("reset");
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Known two-word image, good and then corrupted checksum
        refWords.delete();
        refWords.push_back(32'h2008_0005);
        refWords.push_back(32'h2009_0007);
        applyStimulus(2, 8'h00, 1'b0, -1);
        verifyLoad("good2", 1'b1);
        applyStimulus(2, 8'h01, 1'b0, -1);
        verifyLoad("badchk", 1'b0);

        // Out-of-range counts
        writes.delete();
        rxReadyCycles = 0;
        RxValid = 1'b1;
        pulseStart(0);
        repeat (3) @(negedge CLK);
        checkOutput("count0 Err", 64'(Err), 64'(1));
        checkOutput("count0 CpuHold", 64'(CpuHold), 64'(1));
        pulseStart(DEPTH + 1);
        repeat (3) @(negedge CLK);
        checkOutput("count65 Err", 64'(Err), 64'(1));
        checkOutput("count65 Done", 64'(Done), 64'(0));
        RxValid = 1'b0;
        checkOutput("badcount RxReady cycles", 64'(rxReadyCycles), 64'(0));
        checkOutput("badcount writes", 64'(writes.size()), 64'(0));

        // Full-depth load with random valid gaps
        fillRandom(DEPTH);
        applyStimulus(DEPTH, 8'h00, 1'b1, -1);
        verifyLoad("full", 1'b1);

        // Reset after six bytes of a three-word load
        fillRandom(3);
        writes.delete();
        buildStream(8'h00);
        pulseStart(3);
        sendStream(6, 1'b0, -1);
        RST = 1'b1;
        #1;
        checkResetValues("midreset");
        checkOutput("midreset writes", 64'(writes.size()), 64'(1));
        if (writes.size() > 0)
            checkOutput("midreset word0", 64'(writes[0]), 64'({6'd0, refWords[0]}));
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        fillRandom(1);
        applyStimulus(1, 8'h00, 1'b1, -1);
        verifyLoad("after reset", 1'b1);

        // Start during RECV is ignored, then reload from DONE
        fillRandom(2);
        applyStimulus(2, 8'h00, 1'b0, 2);
        verifyLoad("midstart", 1'b1);
        fillRandom(2);
        writes.delete();
        buildStream(8'h00);
        pulseStart(2);
        checkOutput("reload CpuHold", 64'(CpuHold), 64'(1));
        checkOutput("reload Done", 64'(Done), 64'(0));
        sendStream(stream.size(), 1'b1, -1);
        repeat (3) @(negedge CLK);
        verifyLoad("reload", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
